// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and FSM state encoding.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath: {hi,lo} result from latched
// operands, plus a divide-by-zero flag so the caller can skip the write.
module md_alu
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    quo_s = '0;
    rem_s = '0;
    quo_u = '0;
    rem_u = '0;
    if (b != 32'd0) begin
      // Most-negative / -1 overflows 32 bits; the architected answer is a wrap.
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        quo_s = $signed(a);
        rem_s = '0;
      end else begin
        quo_s = $signed(a) / $signed(b);
        rem_s = $signed(a) % $signed(b);
      end
      quo_u = a / b;
      rem_u = a % b;
    end
  end

  always_comb begin
    result      = '0;
    div_by_zero = is_div(op) && (b == 32'd0);
    unique case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {rem_s, quo_s};
      MD_DIVU:  result = {rem_u, quo_u};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle HI/LO unit: IDLE/BUSY FSM with a latency down-counter,
// the HI/LO architectural registers and the pipeline stall output.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  md_op_e             op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [63:0]        alu_result;
  logic               alu_div_by_zero;

  md_alu u_alu (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .result      (alu_result),
    .div_by_zero (alu_div_by_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = md_op_e'(md_op);
          a_d     = src_a;
          b_d     = src_b;
          cnt_d   = is_div(md_op_e'(md_op)) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = ST_BUSY;
        end else begin
          if (mthi) hi_d = src_a;
          if (mtlo) lo_d = src_a;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          // A zero divisor still burns the full latency but leaves HI/LO alone.
          if (!alu_div_by_zero) begin
            hi_d = alu_result[63:32];
            lo_d = alu_result[31:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == ST_BUSY);
  assign stall = md_use_D & (busy | start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: a scoreboard queue of expected HI/LO
// results and busy lengths, filled at issue and drained when busy falls.
module tb_md_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int BUSY_LIMIT = 40;

  typedef struct {
    string       tag;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic        md_use_D;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  exp_t        sb[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  int          n_checks;
  int          n_errors;

  md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // The pipeline must never issue while busy; any such start is a bench-visible error.
  always @(negedge clk) begin
    if (!reset && start) check("start_while_busy", busy, 1'b0);
  end

  // Reference results computed with 64-bit integer arithmetic, independent of the RTL.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] old);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return old;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return old;
        return {(ua % ub), 32'b0} | {32'b0, 32'(ua / ub)};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and follow it to completion. use_d holds an HI/LO user
  // in D throughout; mv_start raises mthi with start; mv_busy raises mthi/mtlo while busy.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic use_d, input logic mv_start,
                        input logic mv_busy);
    exp_t        e;
    exp_t        got_e;
    logic [63:0] r;
    int          n;
    r        = model(op, a, b, {model_hi, model_lo});
    e.tag    = tag;
    e.cycles = (op[1]) ? DIV_N : MULT_N;
    e.hi     = r[63:32];
    e.lo     = r[31:0];
    sb.push_back(e);

    start    = 1'b1;
    md_op    = op;
    src_a    = a;
    src_b    = b;
    md_use_D = use_d;
    mthi     = mv_start;
    #1;
    check({tag, "_stall_start"}, stall, use_d);
    tick();
    start = 1'b0;
    mthi  = 1'b0;
    check({tag, "_hi_hold"}, hi, model_hi);
    if (mv_busy) begin
      mthi  = 1'b1;
      mtlo  = 1'b1;
      src_a = 32'hDEAD_BEEF;
    end
    n = 0;
    while (busy && n < BUSY_LIMIT) begin
      check({tag, "_stall_busy"}, stall, use_d);
      n++;
      tick();
    end
    mthi = 1'b0;
    mtlo = 1'b0;
    check({tag, "_busy_cycles"}, n, e.cycles);
    check({tag, "_stall_after"}, stall, 1'b0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      got_e = sb.pop_front();
      check({got_e.tag, "_hi"}, hi, got_e.hi);
      check({got_e.tag, "_lo"}, lo, got_e.lo);
      model_hi = got_e.hi;
      model_lo = got_e.lo;
    end
    md_use_D = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_hi = '0;
    model_lo = '0;
    reset    = 1'b1;
    start    = 1'b0;
    md_op    = 2'b00;
    src_a    = '0;
    src_b    = '0;
    mthi     = 1'b0;
    mtlo     = 1'b0;
    md_use_D = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    check("multu_max_hi_const", hi, 32'h0000_0001);
    check("multu_max_lo_const", lo, 32'hFFFF_FFFE);

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0004, 1'b0, 1'b1, 1'b0);
    check("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo_const", lo, 32'hFFFF_FFF4);

    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    check("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    check("div_neg_hi_const", hi, 32'hFFFF_FFFF);

    run_op("divu_zero", 2'b11, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    check("divu_zero_lo_const", lo, 32'hFFFF_FFFD);

    mthi  = 1'b1;
    src_a = 32'h1234_5678;
    tick();
    mthi = 1'b0;
    check("mthi_idle", hi, 32'h1234_5678);
    model_hi = 32'h1234_5678;
    mtlo  = 1'b1;
    src_a = 32'hCAFE_F00D;
    tick();
    mtlo = 1'b0;
    check("mtlo_idle", lo, 32'hCAFE_F00D);
    check("mtlo_idle_hi_kept", hi, 32'h1234_5678);
    model_lo = 32'hCAFE_F00D;

    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    check("div_ovf_lo_const", lo, 32'h8000_0000);
    check("div_ovf_hi_const", hi, 32'h0000_0000);

    for (int i = 0; i < 6; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 5) ra = 32'h8765_4321;
      run_op($sformatf("rand%0d", i), rop, ra, rb, i[0], 1'b0, 1'b0);
    end

    // Abort a mult in its third busy cycle with an asynchronous reset.
    start = 1'b1;
    md_op = 2'b00;
    src_a = 32'h0000_1234;
    src_b = 32'h0000_5678;
    tick();
    start = 1'b0;
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_stall", stall, 1'b0);
    tick();
    reset    = 1'b0;
    model_hi = '0;
    model_lo = '0;
    for (int i = 0; i < 8; i++) tick();
    check("abort_no_write_hi", hi, 32'd0);
    check("abort_no_write_lo", lo, 32'd0);
    check("abort_idle", busy, 1'b0);

    run_op("multu_3x3", 2'b01, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
    check("multu_3x3_lo_const", lo, 32'd9);
    check("multu_3x3_hi_const", hi, 32'd0);

    if (sb.size() != 0) check("sb_drained", sb.size(), 0);
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
